// File: rtl/core_pkg.sv
// Shared types and constants for the instruction memory responder.
`default_nettype none

package core_pkg;

  localparam int IMEM_WORDS = 256;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_BUSY = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state;

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and one read port
// whose data register loads only when a read is enabled.
`default_nettype none

module imem_array
  import core_pkg::*;
#(
  parameter int WORDS = IMEM_WORDS,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  // Same-edge write and read of one word: the read register takes the old value.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/instr_mem_responder.sv
// Single-outstanding instruction fetch responder with fixed response latency
// and a preload write port.
`default_nettype none

module instr_mem_responder
  import core_pkg::*;
#(
  parameter int MEM_WORDS = IMEM_WORDS,
  parameter int LATENCY   = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         instr_req_ip,
  input  logic [31:0]                  instr_addr_ip,
  output logic                         instr_gnt_op,
  output logic                         instr_rvalid_op,
  output logic [31:0]                  instr_rdata_op,
  output logic                         instr_err_op,
  input  logic                         init_we_ip,
  input  logic [$clog2(MEM_WORDS)-1:0] init_addr_ip,
  input  logic [31:0]                  init_data_ip
);

  localparam int         AW     = $clog2(MEM_WORDS);
  localparam logic [2:0] c_LOAD = 3'(LATENCY - 1);

  imem_state   r_state;
  logic [2:0]  r_cnt;
  logic        r_err;

  logic          w_addr_err;
  logic          w_accept;
  logic          w_read_en;
  logic [AW-1:0] w_raddr;
  logic [31:0]   w_arr_rdata;

  assign w_addr_err = (instr_addr_ip[1:0] != 2'b00) ||
                      ({2'b00, instr_addr_ip[31:2]} >= 32'(MEM_WORDS));
  assign w_accept   = reset_n && instr_req_ip && (r_state != IMEM_BUSY);
  assign w_read_en  = w_accept && !w_addr_err;
  assign w_raddr    = instr_addr_ip[AW+1:2];

  imem_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_array (
    .clock   (clock),
    .i_we    (init_we_ip),
    .i_waddr (init_addr_ip),
    .i_wdata (init_data_ip),
    .i_re    (w_read_en),
    .i_raddr (w_raddr),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IMEM_IDLE;
      r_cnt   <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IMEM_IDLE, IMEM_RESP: begin
          if (w_accept) begin
            r_err <= w_addr_err;
            if (LATENCY == 1) begin
              r_state <= IMEM_RESP;
              r_cnt   <= 3'd0;
            end else begin
              r_state <= IMEM_BUSY;
              r_cnt   <= c_LOAD;
            end
          end else begin
            r_state <= IMEM_IDLE;
            r_cnt   <= 3'd0;
          end
        end
        IMEM_BUSY: begin
          // Leaving on the edge that takes the count to zero lands RESP exactly LATENCY edges after acceptance.
          if (r_cnt <= 3'd1) begin
            r_state <= IMEM_RESP;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= IMEM_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  assign instr_gnt_op    = w_accept;
  assign instr_rvalid_op = (r_state == IMEM_RESP);
  assign instr_err_op    = instr_rvalid_op && r_err;
  assign instr_rdata_op  = (instr_rvalid_op && !r_err) ? w_arr_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
// Directed bench: three responder instances (LATENCY 1, 2, 3) share one stimulus bus.
`default_nettype none

module tb_instr_mem_responder;

  logic        clock;
  logic        reset_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wdata;

  logic        gnt1, rv1, er1;
  logic [31:0] rd1;
  logic        gnt2, rv2, er2;
  logic [31:0] rd2;
  logic        gnt3, rv3, er3;
  logic [31:0] rd3;

  int total = 0;
  int bad   = 0;

  instr_mem_responder #(.MEM_WORDS(256), .LATENCY(1)) u1 (
    .clock(clock), .reset_n(reset_n), .instr_req_ip(req), .instr_addr_ip(addr),
    .instr_gnt_op(gnt1), .instr_rvalid_op(rv1), .instr_rdata_op(rd1), .instr_err_op(er1),
    .init_we_ip(we), .init_addr_ip(waddr), .init_data_ip(wdata));

  instr_mem_responder #(.MEM_WORDS(256), .LATENCY(2)) u2 (
    .clock(clock), .reset_n(reset_n), .instr_req_ip(req), .instr_addr_ip(addr),
    .instr_gnt_op(gnt2), .instr_rvalid_op(rv2), .instr_rdata_op(rd2), .instr_err_op(er2),
    .init_we_ip(we), .init_addr_ip(waddr), .init_data_ip(wdata));

  instr_mem_responder #(.MEM_WORDS(256), .LATENCY(3)) u3 (
    .clock(clock), .reset_n(reset_n), .instr_req_ip(req), .instr_addr_ip(addr),
    .instr_gnt_op(gnt3), .instr_rvalid_op(rv3), .instr_rdata_op(rd3), .instr_err_op(er3),
    .init_we_ip(we), .init_addr_ip(waddr), .init_data_ip(wdata));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic init_write(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clock);
    we = 1'b1; waddr = idx; wdata = d;
    @(negedge clock);
    we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One isolated fetch on the LATENCY=2 instance, checking every cycle of it.
  task automatic fetch2(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
    @(negedge clock);
    req = 1'b1; addr = a;
    #1 chk("l2_gnt", 32'(gnt2), 32'd1);
    @(negedge clock);
    req = 1'b0;
    chk("l2_busy_rvalid", 32'(rv2), 32'd0);
    chk("l2_busy_rdata", rd2, 32'd0);
    @(negedge clock);
    chk("l2_rvalid", 32'(rv2), 32'd1);
    chk("l2_rdata", rd2, exp_d);
    chk("l2_err", 32'(er2), 32'(exp_e));
    @(negedge clock);
    chk("l2_after_rvalid", 32'(rv2), 32'd0);
    chk("l2_after_err", 32'(er2), 32'd0);
  endtask

  initial begin
    int seen;
    reset_n = 1'b0; req = 1'b0; addr = 32'd0;
    we = 1'b0; waddr = 8'd0; wdata = 32'd0;

    vecs[0] = '{32'h0000_0010, 32'h00A0_0093, 1'b0};
    vecs[1] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_0000, 32'hAAAA_0001, 1'b0};
    vecs[4] = '{32'h0000_03FC, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{32'h0000_03FD, 32'h0000_0000, 1'b1};

    repeat (2) @(negedge clock);
    req = 1'b1;
    #1;
    chk("rst_gnt", 32'({gnt1, gnt2, gnt3}), 32'd0);
    chk("rst_rvalid", 32'({rv1, rv2, rv3}), 32'd0);
    chk("rst_rdata", rd2, 32'd0);
    chk("rst_err", 32'({er1, er2, er3}), 32'd0);
    req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    init_write(8'd0, 32'hAAAA_0001);
    init_write(8'd1, 32'hBBBB_0002);
    init_write(8'd2, 32'h1111_1111);
    init_write(8'd4, 32'h00A0_0093);
    init_write(8'd255, 32'hCAFE_F00D);
    do_reset();

    for (int i = 0; i < 6; i++) fetch2(vecs[i].addr, vecs[i].rdata, vecs[i].err);

    // LATENCY=1 back-to-back stream with request held high.
    do_reset();
    @(negedge clock);
    req = 1'b1; addr = 32'h0;
    #1 chk("l1_gnt0", 32'(gnt1), 32'd1);
    @(negedge clock);
    chk("l1_rv0", 32'(rv1), 32'd1);
    chk("l1_rd0", rd1, 32'hAAAA_0001);
    addr = 32'h4;
    #1 chk("l1_gnt1", 32'(gnt1), 32'd1);
    @(negedge clock);
    chk("l1_rv1", 32'(rv1), 32'd1);
    chk("l1_rd1", rd1, 32'hBBBB_0002);
    addr = 32'h8;
    #1 chk("l1_gnt2", 32'(gnt1), 32'd1);
    @(negedge clock);
    chk("l1_rv2", 32'(rv1), 32'd1);
    chk("l1_rd2", rd1, 32'h1111_1111);
    req = 1'b0;
    @(negedge clock);
    chk("l1_idle_rv", 32'(rv1), 32'd0);

    // LATENCY=3: a request raised while busy waits for the response cycle.
    do_reset();
    @(negedge clock);
    req = 1'b1; addr = 32'h10;
    #1 chk("l3_gnt_idle", 32'(gnt3), 32'd1);
    @(negedge clock);
    addr = 32'h4;
    #1 chk("l3_gnt_busy_a", 32'(gnt3), 32'd0);
    chk("l3_rv_busy_a", 32'(rv3), 32'd0);
    @(negedge clock);
    #1 chk("l3_gnt_busy_b", 32'(gnt3), 32'd0);
    chk("l3_rv_busy_b", 32'(rv3), 32'd0);
    @(negedge clock);
    chk("l3_rv_resp", 32'(rv3), 32'd1);
    chk("l3_rd_resp", rd3, 32'h00A0_0093);
    #1 chk("l3_gnt_resp", 32'(gnt3), 32'd1);
    @(negedge clock);
    req = 1'b0;
    chk("l3_rv_b1", 32'(rv3), 32'd0);
    @(negedge clock);
    chk("l3_rv_b2", 32'(rv3), 32'd0);
    @(negedge clock);
    chk("l3_rv_2nd", 32'(rv3), 32'd1);
    chk("l3_rd_2nd", rd3, 32'hBBBB_0002);
    @(negedge clock);
    chk("l3_rv_idle", 32'(rv3), 32'd0);

    // Reset one cycle after acceptance aborts the fetch; contents survive.
    do_reset();
    @(negedge clock);
    req = 1'b1; addr = 32'h10;
    @(negedge clock);
    reset_n = 1'b0;
    #1 chk("abort_gnt_in_rst", 32'(gnt2), 32'd0);
    chk("abort_rv_in_rst", 32'(rv2), 32'd0);
    @(negedge clock);
    req = 1'b0; reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rv2) seen++;
    end
    chk("abort_no_rvalid", 32'(seen), 32'd0);
    fetch2(32'h10, 32'h00A0_0093, 1'b0);

    // Same-edge write and read of word 2 returns old data.
    @(negedge clock);
    req = 1'b1; addr = 32'h8;
    we = 1'b1; waddr = 8'd2; wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    req = 1'b0; we = 1'b0;
    @(negedge clock);
    chk("wr_coll_rv", 32'(rv2), 32'd1);
    chk("wr_coll_rd", rd2, 32'h1111_1111);
    @(negedge clock);
    fetch2(32'h8, 32'hDEAD_BEEF, 1'b0);

    // Write during BUSY leaves the in-flight response untouched.
    @(negedge clock);
    req = 1'b1; addr = 32'h10;
    @(negedge clock);
    req = 1'b0;
    we = 1'b1; waddr = 8'd4; wdata = 32'h1234_5678;
    @(negedge clock);
    we = 1'b0;
    chk("wr_busy_rv", 32'(rv2), 32'd1);
    chk("wr_busy_rd", rd2, 32'h00A0_0093);
    @(negedge clock);
    fetch2(32'h10, 32'h1234_5678, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 256, number of 32-bit instruction words held.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response (legal 1..8).
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  reset is asynchronous and active-low.
REQ-005 instr_req_ip  input  1  fetch request; address valid.
REQ-006 instr_addr_ip  input  32  byte address of requested instruction.
REQ-007 instr_gnt_op  output  1  request accepted this cycle.
REQ-008 instr_rvalid_op  output  1  response data valid this cycle.
REQ-009 instr_rdata_op  output  32  instruction word returned.
REQ-010 instr_err_op  output  1  response carries an access error; qualified by instr_rvalid_op.
REQ-011 init_we_ip  input  1  preload write enable.
REQ-012 init_addr_ip  input  $clog2(MEM_WORDS)  preload word index.
REQ-013 init_data_ip  input  32  preload data.

Function
REQ-014 States SHALL be IMEM_IDLE, IMEM_BUSY, IMEM_RESP; single outstanding request only.
REQ-015 instr_gnt_op SHALL be combinational: high iff instr_req_ip high and state is IMEM_IDLE or IMEM_RESP.
REQ-016 Acceptance = posedge with instr_req_ip and instr_gnt_op high; address and read data SHALL be captured at that edge.
REQ-017 After acceptance the FSM SHALL enter IMEM_BUSY with a countdown of LATENCY-1, or enter IMEM_RESP directly if LATENCY=1.
REQ-018 In IMEM_BUSY the counter SHALL decrement each cycle; at zero the next state SHALL be IMEM_RESP.
REQ-019 instr_rvalid_op SHALL be high for exactly one cycle (state IMEM_RESP), LATENCY cycles after the accepting edge.
REQ-020 From IMEM_RESP: new acceptance -> IMEM_BUSY/IMEM_RESP per REQ-017 (back-to-back); otherwise -> IMEM_IDLE.
REQ-021 Error SHALL be flagged when addr[1:0]!=0 or addr[31:2]>=MEM_WORDS; then instr_rdata_op=0 and instr_err_op=1; grant is still given.
REQ-022 instr_rdata_op and instr_err_op SHALL be 0 whenever instr_rvalid_op is low.
REQ-023 init_we_ip SHALL write the array at posedge in any state.
REQ-024 Init write and accepted read to the same word at the same edge: the read SHALL return the old data.
REQ-025 Init writes after acceptance SHALL NOT alter the in-flight response.
REQ-026 instr_req_ip seen in IMEM_BUSY SHALL be ignored (no grant); the requester holds it.

Reset
REQ-027 reset_n low SHALL immediately force IMEM_IDLE, counter 0, instr_rvalid_op=0, instr_rdata_op=0, instr_err_op=0.
REQ-028 Reset mid-request SHALL abort it silently: no response after release.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 instr_gnt_op SHALL be 0 while reset_n is low.

Structure
REQ-031 CORE_PKG SHALL hold the imem_state enum (IMEM_IDLE, IMEM_BUSY, IMEM_RESP) and the IMEM_WORDS default constant.
REQ-032 Storage SHALL be a sub-module imem_array: 1 synchronous write port, 1 read port registered at acceptance.

Verification
REQ-033 Preload word 4 = 0x00A00093; req addr 0x10, LATENCY=2 -> gnt same cycle, rvalid 2 cycles later, rdata 0x00A00093, err 0.
REQ-034 req held continuously for addrs 0x0, 0x4, 0x8, LATENCY=1 -> gnt every cycle, three consecutive rvalid pulses in order.
REQ-035 req addr 0x6 and addr 0x400 (MEM_WORDS=256) -> each gets gnt, rvalid with err=1, rdata=0.
REQ-036 LATENCY=3, second req raised in BUSY -> gnt stays low until the RESP cycle, then is accepted.
REQ-037 reset_n pulsed low 1 cycle after acceptance -> rvalid never asserts; preloaded word still readable after release.
REQ-038 init write 0xDEADBEEF to word 2 at the acceptance edge of addr 0x8 (old 0x11111111) -> rdata 0x11111111; next read -> 0xDEADBEEF.
